// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared command and FSM state encodings for the SPI RAM burst block
package spi_ram_pkg;

    typedef enum logic [1:0] {
        SET_WADDR = 2'b00,
        WRITE     = 2'b01,
        SET_RADDR = 2'b10,
        READ      = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_array.sv
// spi_ram_array: word storage with one synchronous write port and one registered read port
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
    input  logic [ADDR_SIZE-1:0]         wdata_i,
    input  logic                         re_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
    output logic [ADDR_SIZE-1:0]         rdata_o
);

    logic [ADDR_SIZE-1:0] mem_q [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] rdata_q;

    // Storage is deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read data register only moves on an accepted read, so it holds while a response waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM with held read responses and address range checking
// Define RAM_AUTOINC_EN to advance waddr after each WRITE and raddr after each accepted READ.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 tx_ready,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 busy,
    output logic                 addr_err
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 bad_addr;
    logic                 set_w, set_r, we, re, inc_w, inc_r;
    logic [AW-1:0]        waddr_q, waddr_d, raddr_q, raddr_d, waddr_nx, raddr_nx;
    logic                 err_q, err_d;
    state_e               state_q, state_d;

    assign cmd      = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload  = din[ADDR_SIZE-1:0];
    assign bad_addr = {1'b0, payload} >= DEPTH;
    assign set_w    = rx_valid && cmd == SET_WADDR;
    assign set_r    = rx_valid && cmd == SET_RADDR;
    assign we       = rx_valid && cmd == WRITE;
    // A read is taken when idle, or when the pending response is being consumed this cycle
    assign re       = rx_valid && cmd == READ && (state_q == IDLE || tx_ready);
    assign waddr_nx = waddr_q == LAST ? '0 : waddr_q + AW'(1);
    assign raddr_nx = raddr_q == LAST ? '0 : raddr_q + AW'(1);

`ifdef RAM_AUTOINC_EN
    assign inc_w = we;
    assign inc_r = re;
`else
    assign inc_w = 1'b0;
    assign inc_r = 1'b0;
`endif

    // Address register updates; out-of-range loads are dropped and flagged
    always_comb begin
        waddr_d = set_w ? (bad_addr ? waddr_q : payload[AW-1:0]) : inc_w ? waddr_nx : waddr_q;
        raddr_d = set_r ? (bad_addr ? raddr_q : payload[AW-1:0]) : inc_r ? raddr_nx : raddr_q;
        err_d   = (set_w || set_r) && bad_addr;
    end

    // Response FSM: stay in HOLD until consumed, or re-enter it on a back-to-back read
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = re ? HOLD : IDLE;
        else if (tx_ready) state_d = re ? HOLD : IDLE;
    end

    // State and address registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
        end
    end

    spi_ram_array #(
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we),
        .waddr_i(waddr_q),
        .wdata_i(payload),
        .re_i   (re),
        .raddr_i(raddr_q),
        .rdata_o(dout)
    );

    assign tx_valid = state_q == HOLD;
    assign busy     = state_q == HOLD;
    assign addr_err = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: scoreboard bench for spi_ram_burst with ADDR_SIZE=8, MEM_DEPTH=200
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n, rx_valid, tx_ready;
    logic [9:0] din;
    logic [7:0] dout;
    logic       tx_valid, busy, addr_err;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] sb_q [$];
    logic [7:0] exp_mem [200];
    logic [7:0] m_waddr, m_raddr, hv;
    logic       m_hold;

    spi_ram_burst #(.ADDR_SIZE(8), .MEM_DEPTH(200)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_valid(rx_valid),
        .din     (din),
        .tx_ready(tx_ready),
        .dout    (dout),
        .tx_valid(tx_valid),
        .busy    (busy),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every handshake seen before a rising edge transfers the oldest expected word
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) check("unexpected_resp", {24'd0, dout}, 32'hFFFF_FFFF);
            else check("sb_dout", {24'd0, dout}, {24'd0, sb_q.pop_front()});
        end
    end

    task automatic step(input logic v, input logic [1:0] c, input logic [7:0] p);
        logic rd, err;
        rx_valid = v;
        din = {c, p};
        rd = v && c == 2'd3 && (!m_hold || tx_ready);
        err = v && (c == 2'd0 || c == 2'd2) && p >= 8'd200;
        if (rd) sb_q.push_back(exp_mem[m_raddr]);
        if (v && c == 2'd0 && !err) m_waddr = p;
        if (v && c == 2'd2 && !err) m_raddr = p;
        if (v && c == 2'd1) begin
            exp_mem[m_waddr] = p;
`ifdef RAM_AUTOINC_EN
            m_waddr = m_waddr == 8'd199 ? 8'd0 : m_waddr + 8'd1;
`endif
        end
`ifdef RAM_AUTOINC_EN
        if (rd) m_raddr = m_raddr == 8'd199 ? 8'd0 : m_raddr + 8'd1;
`endif
        m_hold = rd ? 1'b1 : (m_hold && tx_ready) ? 1'b0 : m_hold;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("busy", {31'd0, busy}, {31'd0, m_hold});
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_hold});
        check("addr_err", {31'd0, addr_err}, {31'd0, err});
    endtask

    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0;
        din = '0;
        tx_ready = 1'b0;
        m_hold = 1'b0;
        m_waddr = '0;
        m_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Write path
        tx_ready = 1'b1;
        step(1, 2'd0, 8'h10);
        step(1, 2'd1, 8'hA5);
        step(1, 2'd2, 8'h10);
        step(1, 2'd3, 8'h00);
        check("wr_dout", {24'd0, dout}, 32'hA5);
        step(0, 2'd0, 8'h00);
        // Range check
        step(1, 2'd0, 8'hC8);
        step(0, 2'd0, 8'h00);
        step(1, 2'd1, 8'h5A);
        step(1, 2'd0, 8'hC7);
        // Wrap behaviour at the top address
        step(1, 2'd0, 8'h00);
        step(1, 2'd1, 8'h33);
        step(1, 2'd0, 8'hC7);
        step(1, 2'd1, 8'h11);
        step(1, 2'd1, 8'h22);
        step(1, 2'd2, 8'hC7);
        step(1, 2'd3, 8'h00);
`ifdef RAM_AUTOINC_EN
        check("inc_199", {24'd0, dout}, 32'h11);
`else
        check("inc_199", {24'd0, dout}, 32'h22);
`endif
        step(1, 2'd2, 8'h00);
        step(1, 2'd3, 8'h00);
`ifdef RAM_AUTOINC_EN
        check("inc_0", {24'd0, dout}, 32'h22);
`else
        check("inc_0", {24'd0, dout}, 32'h33);
`endif
        step(0, 2'd0, 8'h00);
        // Hold with consumer stalled; a second read must be ignored
        tx_ready = 1'b0;
        step(1, 2'd2, 8'h10);
        hv = exp_mem[m_raddr];
        step(1, 2'd3, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd0, 8'h00);
            check("hold_dout", {24'd0, dout}, {24'd0, hv});
        end
        step(1, 2'd3, 8'h00);
        check("hold_ignored", {24'd0, dout}, {24'd0, hv});
        tx_ready = 1'b1;
        step(0, 2'd0, 8'h00);
        // Back-to-back read from HOLD
        step(1, 2'd0, 8'h20);
        step(1, 2'd1, 8'h01);
        step(1, 2'd0, 8'h21);
        step(1, 2'd1, 8'h02);
        tx_ready = 1'b0;
        step(1, 2'd2, 8'h20);
        step(1, 2'd3, 8'h00);
        check("b2b_first", {24'd0, dout}, 32'h01);
        step(1, 2'd2, 8'h21);
        tx_ready = 1'b1;
        step(1, 2'd3, 8'h00);
        check("b2b_second", {24'd0, dout}, 32'h02);
        step(0, 2'd0, 8'h00);
        // Reset while a response is pending
        step(1, 2'd0, 8'h30);
        step(1, 2'd1, 8'h77);
        tx_ready = 1'b0;
        step(1, 2'd2, 8'h30);
        step(1, 2'd3, 8'h00);
        rst_n = 1'b0;
        #1;
        check("rst_hold_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        check("rst_hold_dout", {24'd0, dout}, 32'd0);
        sb_q.delete();
        m_hold = 1'b0;
        m_waddr = '0;
        m_raddr = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        step(1, 2'd2, 8'h30);
        step(1, 2'd3, 8'h00);
        check("rst_keep_mem", {24'd0, dout}, 32'h77);
        step(0, 2'd0, 8'h00);
        step(0, 2'd0, 8'h00);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
